// File: rtl/reg8_pkg.sv
// ---------------------------------------------------------------------------
// reg8_pkg : shared state encodings and line levels for the reg8 serial path
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package reg8_pkg;

    localparam int DATA_W = 8;

    localparam logic IDLE_LEVEL = 1'b1;
    localparam logic STOP_LEVEL = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/reg8_bit_tick.sv
// ---------------------------------------------------------------------------
// reg8_bit_tick : bit-period divider producing a bit_end strobe
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module reg8_bit_tick #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic bit_end_o
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] div_d;
    logic             w_last;

    // With one clock per bit LAST_CNT is zero, so the counter never leaves 0.
    assign w_last    = (div_q == LAST_CNT);
    assign bit_end_o = en_i && w_last;

    always_comb begin
        div_d = div_q;
        if (clr_i) begin
            div_d = '0;
        end else if (en_i) begin
            div_d = w_last ? '0 : div_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/reg8_serial_tx.sv
// ---------------------------------------------------------------------------
// reg8_serial_tx : framed serial transmitter (start, 8 data, stop) for reg8
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module reg8_serial_tx
    import reg8_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter bit LSB_FIRST    = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              start,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    tx_state_t         state_q, state_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              w_bit_end;
    logic              w_tick_clr;
    logic [DATA_W-1:0] w_sh_shift;
    logic              w_first_bit;
    logic              w_next_bit;

    assign w_tick_clr = (state_q == ST_IDLE);

    reg8_bit_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_tick (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (w_tick_clr),
        .en_i      (!w_tick_clr),
        .bit_end_o (w_bit_end)
    );

    // The next bit is taken from the pre-shift word so tx can be registered
    // on the same edge the shift register moves.
    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign w_sh_shift  = {1'b0, sh_q[DATA_W-1:1]};
            assign w_first_bit = sh_q[0];
            assign w_next_bit  = sh_q[1];
        end else begin : g_msb_first
            assign w_sh_shift  = {sh_q[DATA_W-2:0], 1'b0};
            assign w_first_bit = sh_q[DATA_W-1];
            assign w_next_bit  = sh_q[DATA_W-2];
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                tx_d   = IDLE_LEVEL;
                busy_d = 1'b0;
                if (start) begin
                    sh_d    = din;
                    state_d = ST_START;
                    busy_d  = 1'b1;
                    tx_d    = 1'b0;
                end
            end
            ST_START: begin
                tx_d = 1'b0;
                if (w_bit_end) begin
                    state_d = ST_DATA;
                    cnt_d   = 3'd0;
                    tx_d    = w_first_bit;
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    sh_d  = w_sh_shift;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = STOP_LEVEL;
                    end else begin
                        tx_d = w_next_bit;
                    end
                end
            end
            ST_STOP: begin
                tx_d = STOP_LEVEL;
                if (w_bit_end) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = IDLE_LEVEL;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            cnt_q   <= 3'd0;
            tx_q    <= IDLE_LEVEL;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_reg8_serial_tx.sv
// ---------------------------------------------------------------------------
// tb_reg8_serial_tx : directed bench for reg8_serial_tx
// Revision          : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_reg8_serial_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din_l = 8'h00, din_m = 8'h00, din_1 = 8'h00;
    logic       start_l = 1'b0, start_m = 1'b0, start_1 = 1'b0;
    logic       tx_l, busy_l, done_l;
    logic       tx_m, busy_m, done_m;
    logic       tx_1, busy_1, done_1;

    always #5 clk = ~clk;

    reg8_serial_tx #(.CLKS_PER_BIT(4), .LSB_FIRST(1'b1)) dut_l (
        .clk(clk), .rst(rst), .din(din_l), .start(start_l),
        .tx(tx_l), .busy(busy_l), .done(done_l)
    );
    reg8_serial_tx #(.CLKS_PER_BIT(4), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .rst(rst), .din(din_m), .start(start_m),
        .tx(tx_m), .busy(busy_m), .done(done_m)
    );
    reg8_serial_tx #(.CLKS_PER_BIT(1), .LSB_FIRST(1'b1)) dut_1 (
        .clk(clk), .rst(rst), .din(din_1), .start(start_1),
        .tx(tx_1), .busy(busy_1), .done(done_1)
    );

    int   sel = 0;
    logic tx_s, busy_s, done_s;

    always_comb begin
        tx_s   = tx_l;
        busy_s = busy_l;
        done_s = done_l;
        case (sel)
            1: begin tx_s = tx_m; busy_s = busy_m; done_s = done_m; end
            2: begin tx_s = tx_1; busy_s = busy_1; done_s = done_1; end
            default: ;
        endcase
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%b required=%b", nm, $time, act, exp);
        end
    endtask

    task automatic set_in(input int s, input logic [7:0] d, input logic st);
        case (s)
            1:       begin din_m = d; start_m = st; end
            2:       begin din_1 = d; start_1 = st; end
            default: begin din_l = d; start_l = st; end
        endcase
    endtask

    // Drive start from a negedge so edge E is the following posedge.
    task automatic launch(input int s, input logic [7:0] d, input logic hold);
        sel = s;
        @(negedge clk);
        set_in(s, d, 1'b1);
        @(posedge clk);
        #1;
        if (!hold) set_in(s, d, 1'b0);
    endtask

    // bits[i] is the line level of the i-th bit-time after edge E.
    task automatic check_frame(input int cpb, input logic [9:0] bits,
                               input string nm, input int coll_at);
        for (int k = 0; k < 10 * cpb; k++) begin
            @(negedge clk);
            chk({nm, " tx"}, tx_s, bits[k / cpb]);
            chk({nm, " busy"}, busy_s, 1'b1);
            chk({nm, " done_early"}, done_s, 1'b0);
            if (coll_at >= 0 && k == coll_at)     set_in(sel, 8'hFF, 1'b1);
            if (coll_at >= 0 && k == coll_at + 1) set_in(sel, 8'hFF, 1'b0);
        end
        @(negedge clk);
        chk({nm, " busy_end"}, busy_s, 1'b0);
        chk({nm, " done_pulse"}, done_s, 1'b1);
        chk({nm, " tx_idle"}, tx_s, 1'b1);
    endtask

    task automatic check_idle(input int n, input string nm);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            chk({nm, " tx"}, tx_s, 1'b1);
            chk({nm, " busy"}, busy_s, 1'b0);
            chk({nm, " done"}, done_s, 1'b0);
        end
    endtask

    typedef struct {
        int         s;
        int         cpb;
        logic [7:0] d;
        logic [9:0] bits;
        string      nm;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{0, 4, 8'hA5, 10'b1101001010, "lsb_A5"};
        vecs[1] = '{1, 4, 8'h81, 10'b1100000010, "msb_81"};
        vecs[2] = '{2, 1, 8'hA5, 10'b1101001010, "cpb1_A5"};
        vecs[3] = '{1, 4, 8'hC3, 10'b1110000110, "msb_C3"};
        vecs[4] = '{0, 4, 8'h0F, 10'b1000011110, "lsb_0F"};

        // Reset held low with start asserted on every instance.
        #1 rst = 1'b0;
        set_in(0, 8'hA5, 1'b1);
        set_in(1, 8'hA5, 1'b1);
        set_in(2, 8'hA5, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst tx_l", tx_l, 1'b1);
            chk("rst busy_l", busy_l, 1'b0);
            chk("rst done_l", done_l, 1'b0);
            chk("rst busy_m", busy_m, 1'b0);
            chk("rst busy_1", busy_1, 1'b0);
        end
        set_in(0, 8'h00, 1'b0);
        set_in(1, 8'h00, 1'b0);
        set_in(2, 8'h00, 1'b0);
        rst = 1'b1;
        sel = 0;
        check_idle(2, "post_rst");

        for (int i = 0; i < 5; i++) begin
            launch(vecs[i].s, vecs[i].d, 1'b0);
            check_frame(vecs[i].cpb, vecs[i].bits, vecs[i].nm, -1);
            check_idle(2, {vecs[i].nm, " after"});
        end

        // Collision: second request mid-frame with different data is dropped.
        launch(0, 8'h3C, 1'b0);
        check_frame(4, 10'b1001111000, "coll_3C", 12);
        check_idle(8, "coll_no_queue");

        // Back-to-back: start held, second frame begins the edge after done.
        launch(0, 8'h01, 1'b1);
        din_l = 8'h02;
        check_frame(4, 10'b1000000010, "b2b_01", -1);
        @(posedge clk);
        #1 set_in(0, 8'h02, 1'b0);
        check_frame(4, 10'b1000000100, "b2b_02", -1);
        check_idle(2, "b2b_after");

        // Reset in the middle of a frame.
        launch(0, 8'h55, 1'b0);
        for (int k = 0; k < 17; k++) @(negedge clk);
        chk("mid busy_before", busy_l, 1'b1);
        rst = 1'b0;
        #1;
        chk("mid_rst tx", tx_l, 1'b1);
        chk("mid_rst busy", busy_l, 1'b0);
        chk("mid_rst done", done_l, 1'b0);
        check_idle(2, "mid_rst_hold");
        rst = 1'b1;
        check_idle(45, "mid_rst_no_done");
        launch(0, 8'h0F, 1'b0);
        check_frame(4, 10'b1000011110, "post_rst_0F", -1);
        check_idle(2, "final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/reg8_serial_tx.md
Name: reg8_serial_tx

Overview:
- Downstream consumer of the 8-bit load/increment register stage.
- Takes the register's parallel 8-bit output on a start strobe and shifts it out on a single serial line as a framed word: start bit, 8 data bits, stop bit.
- Reports busy while a frame is in flight and pulses done when the frame completes.
- Bit timing comes from an internal clock-enable divider.

Parameters:
- CLKS_PER_BIT, 4, clk cycles per serial bit; legal range 1..255.
- LSB_FIRST, 1, 1 = data bit 0 sent first; 0 = data bit 7 sent first.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- din  input  8  parallel word; connected to the register stage's out.
- start  input  1  request to send din; sampled on the rising edge.
- tx  output  1  serial line; idles high; registered output.
- busy  output  1  high from frame acceptance until the stop bit ends.
- done  output  1  one-cycle pulse after the stop bit ends.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, tx=1, busy=0, done=0, shift register=0x00, bit counter=0, divider=0.
- Reset mid-frame aborts the frame; tx returns high immediately, with no done pulse.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1.
  - If start=1 at edge E: capture din into the shift register, state=START, busy=1, tx=0, divider=0.
  - start is level-sampled; a held start produces back-to-back frames.
- Divider:
  - Counts 0..CLKS_PER_BIT-1 in every non-IDLE state.
  - bit_end is asserted when divider == CLKS_PER_BIT-1.
  - Each bit occupies exactly CLKS_PER_BIT cycles.
- START: tx=0. On bit_end: state=DATA, bit counter=0, tx = first data bit.
- DATA:
  - tx = current bit.
  - On bit_end, shift right (LSB_FIRST=1) or left (LSB_FIRST=0) and increment the bit counter.
  - When bit_end occurs with bit counter==7: state=STOP, tx=1.
- STOP:
  - tx=1.
  - On bit_end: state=IDLE, busy=0, done=1 for exactly one cycle.
- Frame length: 10*CLKS_PER_BIT cycles from edge E to the edge where busy falls.
- done cycle: IDLE rules apply.
  - If start=1 at the following edge, a new frame begins, giving zero idle bit-times between frames.
- start while busy=1 is ignored and not queued.
- din changes during a frame have no effect; the word is captured only at edge E.
- tx, busy and done are all driven from flops, so there are no combinational paths from inputs to outputs.
- CLKS_PER_BIT=1: divider is constant 0, bit_end is always 1, frame is 10 cycles.

Decomposition:
- Shared package/header reg8_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_START=2'd1, ST_DATA=2'd2, ST_STOP=2'd3;
  - DATA_W=8;
  - idle and stop line levels, both =1.
- One natural sub-module: reg8_bit_tick.
  - Parameterised CLKS_PER_BIT divider with clear/enable inputs.
  - Produces the bit_end strobe.
  - Same reset style: rst asynchronous, active-low.
- Main block holds the FSM in the two-block register/next-state style used across the codebase.

Test Plan:
- Reset: hold rst=0 for 3 cycles with start=1 -> tx=1, busy=0, done=0 throughout; no frame starts until rst=1.
- Basic frame (CLKS_PER_BIT=4, LSB_FIRST=1), din=8'hA5, start pulse -> tx per 4-cycle bit is 0,1,0,1,0,0,1,0,1,1; busy high for 40 cycles; done pulses once at cycle 40.
- MSB-first (LSB_FIRST=0), din=8'h81 -> tx bits 0,1,0,0,0,0,0,0,1,1; 40 cycles total.
- Collision: start frame with din=8'h3C, then pulse start again at cycle 12 while din=8'hFF -> second request ignored; serial data equals 8'h3C; exactly one done pulse.
- Back-to-back: hold start=1 with din=8'h01 then 8'h02 -> second frame's start bit begins the cycle after done; frames 8'h01 and 8'h02 are correct with no idle high bit-time between them.
- Reset mid-frame: assert rst=0 at cycle 17 of a frame for din=8'h55 -> tx=1, busy=0 immediately; no done; after release, a new start with din=8'h0F transmits cleanly.
